load_extend_unit: RTL and testbench

Parametrised, pipelined load-data extender for the mips32 datapath. It replaces fixed 16-to-32 zero extension with byte/halfword/word lane selection and selectable sign or zero extension. It sits between the data-memory read port and register-file writeback. It has a two-stage valid/ready pipeline that carries a destination tag, and it flags misaligned accesses.

---
 rtl/load_extend_unit.sv | 177 +++++++++++++++++
 tb/tb_load_extend_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_extend_unit.sv
// load_extend_unit
//
// Pipelined load-data extender placed between the data-memory read port and
// register-file writeback. Picks a byte, halfword or full word lane out of the
// raw memory word, right-justifies it, then sign- or zero-extends it to
// DATA_W bits. A destination tag rides along with each request, and accesses
// that are misaligned or use the reserved size code come out flagged with
// out_err=1 and out_data=0.
//
// Pipeline: stage 1 aligns (lane select), stage 2 extends. Each stage is
// either EMPTY or FULL (s1_v / s2_v). Stage 2 holds the registered outputs.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   reset      - asynchronous, active-high; clears all state
//   in_valid   - request present
//   in_ready   - request accepted this cycle (combinational from out_ready)
//   in_word    - raw memory word, byte k = in_word[8k+7:8k]
//   in_off     - byte offset of the access within in_word
//   in_size    - 00 byte, 01 halfword, 10 word, 11 reserved
//   in_signed  - 1 = sign-extend, 0 = zero-extend
//   in_tag     - destination tag, passed through unchanged
//   out_valid  - result present
//   out_ready  - consumer accepts the result this cycle
//   out_data   - extended result (0 when out_err=1)
//   out_err    - misaligned or reserved-size request
//   out_tag    - tag of the request this result belongs to

module load_extend_unit #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_word,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [TAG_W-1:0]  out_tag
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Stage occupancy.
  logic s1_v;
  logic s2_v;

  // Stage 1 (align) payload.
  logic [DATA_W-1:0] s1_lane_reg;
  logic [1:0]        s1_size_reg;
  logic              s1_signed_reg;
  logic [TAG_W-1:0]  s1_tag_reg;
  logic              s1_err_reg;

  // Stage 2 (extend) payload, drives the outputs directly.
  logic [DATA_W-1:0] out_data_reg;
  logic              out_err_reg;
  logic [TAG_W-1:0]  out_tag_reg;

  // Handshake.
  logic in_accept;
  logic s2_load;

  assign in_ready  = !s1_v || !s2_v || out_ready;
  assign in_accept = in_valid && in_ready;
  assign s2_load   = s1_v && (!s2_v || out_ready);

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: lane alignment and error classification.
  // ---------------------------------------------------------------------------
  logic [OFF_W+2:0]  shift_amt;
  logic [DATA_W-1:0] shifted_word;
  logic              err_next;

  // Right-justify the addressed byte. For word accesses the only legal offset
  // is zero, so the shifted word equals in_word whenever the result is used;
  // higher bits left over for byte/halfword are overwritten in stage 2.
  assign shift_amt    = {in_off, 3'b000};
  assign shifted_word = in_word >> shift_amt;

  always_comb begin
    err_next = 1'b0;
    case (in_size)
      SZ_BYTE: err_next = 1'b0;
      SZ_HALF: err_next = in_off[0];
      SZ_WORD: err_next = (in_off != '0);
      default: err_next = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: fill above the lane width.
  // ---------------------------------------------------------------------------
  logic              fill_byte;
  logic              fill_half;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] data_next;

  assign fill_byte = s1_signed_reg & s1_lane_reg[7];
  assign fill_half = s1_signed_reg & s1_lane_reg[15];

  // Per-bit fill selection. Bits 0..7 are always lane data; bits 8..15 are
  // lane data unless the access is a byte; bits 16 and up are lane data only
  // for full-word accesses.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_ext
      if (gi < 8) begin : g_low
        assign ext_data[gi] = s1_lane_reg[gi];
      end else if (gi < 16) begin : g_mid
        assign ext_data[gi] = (s1_size_reg == SZ_BYTE) ? fill_byte : s1_lane_reg[gi];
      end else begin : g_high
        assign ext_data[gi] = (s1_size_reg == SZ_BYTE) ? fill_byte :
                              (s1_size_reg == SZ_HALF) ? fill_half :
                                                         s1_lane_reg[gi];
      end
    end
  endgenerate

  // Erroneous requests still flow through with their tag, but carry no data.
  assign data_next = s1_err_reg ? '0 : ext_data;

  // ---------------------------------------------------------------------------
  // State.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v          <= 1'b0;
      s2_v          <= 1'b0;
      s1_lane_reg   <= '0;
      s1_size_reg   <= '0;
      s1_signed_reg <= 1'b0;
      s1_tag_reg    <= '0;
      s1_err_reg    <= 1'b0;
      out_data_reg  <= '0;
      out_err_reg   <= 1'b0;
      out_tag_reg   <= '0;
    end else begin
      // Stage 1: refill on accept, otherwise empties when stage 2 takes it.
      if (in_accept) begin
        s1_v          <= 1'b1;
        s1_lane_reg   <= shifted_word;
        s1_size_reg   <= in_size;
        s1_signed_reg <= in_signed;
        s1_tag_reg    <= in_tag;
        s1_err_reg    <= err_next;
      end else if (s2_load) begin
        s1_v <= 1'b0;
      end

      // Stage 2: payload only changes on load, so a stalled result holds.
      if (s2_load) begin
        s2_v         <= 1'b1;
        out_data_reg <= data_next;
        out_err_reg  <= s1_err_reg;
        out_tag_reg  <= s1_tag_reg;
      end else if (out_ready) begin
        s2_v <= 1'b0;
      end
    end
  end

  assign out_valid = s2_v;
  assign out_data  = out_data_reg;
  assign out_err   = out_err_reg;
  assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_load_extend_unit.sv
module tb_load_extend_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 32-bit instance
  logic        in_valid, in_ready, in_signed;
  logic [31:0] in_word;
  logic [1:0]  in_off, in_size;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  // 64-bit instance
  logic        w_in_valid, w_in_ready, w_in_signed;
  logic [63:0] w_in_word;
  logic [2:0]  w_in_off;
  logic [1:0]  w_in_size;
  logic [4:0]  w_in_tag;
  logic        w_out_valid, w_out_ready, w_out_err;
  logic [63:0] w_out_data;
  logic [4:0]  w_out_tag;

  load_extend_unit #(.DATA_W(32), .TAG_W(5)) u0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_off(in_off),
    .in_size(in_size), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .out_tag(out_tag)
  );

  load_extend_unit #(.DATA_W(64), .TAG_W(5)) u1 (
    .clk(clk), .reset(reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_word(w_in_word), .in_off(w_in_off),
    .in_size(w_in_size), .in_signed(w_in_signed), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_err(w_out_err), .out_tag(w_out_tag)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit check_lat = 1'b0;
  bit last_acc  = 1'b0;

  typedef struct {
    logic [31:0] d;
    logic        e;
    logic [4:0]  t;
    int          acc;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: pick the addressed lane arithmetically, then widen it as a
  // signed or unsigned number of 'width' bits to dw bits.
  function automatic void model(input logic [63:0] w, input int off, input int sz,
                                input bit sgn, input int dw,
                                output logic [63:0] d, output bit e);
    int width;
    logic [63:0] lane, lmask, dmask;
    e = (sz == 3) || (sz == 1 && (off % 2) == 1) || (sz == 2 && off != 0);
    width = (sz == 0) ? 8 : (sz == 1) ? 16 : dw;
    lmask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    dmask = (dw >= 64) ? {64{1'b1}} : ((64'd1 << dw) - 64'd1);
    lane  = (w >> (8 * off)) & lmask;
    if (sgn && width < dw && lane[width-1]) lane = lane | ~lmask;
    d = e ? 64'd0 : (lane & dmask);
  endfunction

  task automatic drive(input bit v, input logic [31:0] w, input int off, input int sz,
                       input bit sgn, input logic [4:0] tag);
    in_valid  = v;
    in_word   = w;
    in_off    = off[1:0];
    in_size   = sz[1:0];
    in_signed = sgn;
    in_tag    = tag;
  endtask

  // One clock cycle on the 32-bit instance; entered and left just after a negedge.
  task automatic tick();
    exp_t h;
    logic [63:0] md;
    bit me;
    #1;
    if (check_lat && q.size() > 0 && cyc == q[0].acc + 2)
      chk("latency_valid", 64'(out_valid), 64'd1);
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        h = q[0];
        chk("out_data", 64'(out_data), 64'(h.d));
        chk("out_err",  64'(out_err),  64'(h.e));
        chk("out_tag",  64'(out_tag),  64'(h.t));
        if (out_ready) void'(q.pop_front());
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      model(64'(in_word), int'(in_off), int'(in_size), in_signed, 32, md, me);
      h.d = md[31:0];
      h.e = me;
      h.t = in_tag;
      h.acc = cyc;
      q.push_back(h);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] w, input int off, input int sz,
                      input bit sgn, input logic [4:0] tag);
    int n = 0;
    drive(1'b1, w, off, sz, sgn, tag);
    do begin
      tick();
      n++;
    end while (!last_acc && n < 20);
    chk("accept_timeout", 64'(last_acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    tick();
  endtask

  task automatic wide_req(input logic [63:0] w, input int off, input int sz,
                          input bit sgn, input logic [4:0] tag);
    logic [63:0] md;
    bit me;
    w_in_valid  = 1'b1;
    w_in_word   = w;
    w_in_off    = off[2:0];
    w_in_size   = sz[1:0];
    w_in_signed = sgn;
    w_in_tag    = tag;
    model(w, off, sz, sgn, 64, md, me);
    #1 chk("w_in_ready", 64'(w_in_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    w_in_valid = 1'b0;
    chk("w_not_yet_valid", 64'(w_out_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("w_out_valid", 64'(w_out_valid), 64'd1);
    chk("w_out_data",  w_out_data,       md);
    chk("w_out_err",   64'(w_out_err),   64'(me));
    chk("w_out_tag",   64'(w_out_tag),   64'(tag));
    @(posedge clk); @(negedge clk);
  endtask

  localparam logic [31:0] TW = 32'h80FF7F01;

  initial begin
    reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 32'd0, 0, 0, 1'b0, 5'd0);
    w_in_valid = 1'b0; w_in_word = '0; w_in_off = '0; w_in_size = '0;
    w_in_signed = 1'b0; w_in_tag = '0; w_out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_err",   64'(out_err),   64'd0);
    chk("rst_out_tag",   64'(out_tag),   64'd0);
    chk("rst_w_out_valid", 64'(w_out_valid), 64'd0);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Lane select and sign/zero fill, back-to-back
    check_lat = 1'b1;
    send(TW, 1, 0, 1'b0, 5'd1);
    send(TW, 3, 0, 1'b1, 5'd2);
    send(TW, 2, 0, 1'b0, 5'd3);
    send(TW, 2, 1, 1'b1, 5'd4);
    send(TW, 0, 1, 1'b1, 5'd5);
    send(TW, 0, 2, 1'b0, 5'd6);
    drain();

    // Misaligned / reserved, followed by a normal request
    send(TW, 1, 1, 1'b1, 5'd10);
    send(TW, 2, 2, 1'b0, 5'd11);
    send(TW, 0, 3, 1'b0, 5'd12);
    send(TW, 0, 0, 1'b1, 5'd13);
    drain();

    // Backpressure
    check_lat = 1'b0;
    out_ready = 1'b0;
    send(TW, 0, 0, 1'b0, 5'd20);
    send(TW, 3, 0, 1'b1, 5'd21);
    drive(1'b1, TW, 2, 1, 1'b1, 5'd22);
    #1 chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    repeat (3) tick();
    chk("bp_no_accept", 64'(last_acc), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_refill_same_cycle", 64'(last_acc), 64'd1);
    drain();

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    send(TW, 1, 0, 1'b1, 5'd30);
    send(TW, 2, 1, 1'b0, 5'd31);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_out_data",  64'(out_data),  64'd0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("post_rst_quiet", 64'(out_valid), 64'd0);
      tick();
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)), 5'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Random traffic, always-ready consumer: fixed latency
    check_lat = 1'b1;
    for (int i = 0; i < 50; i++) begin
      drive($urandom_range(0, 1) != 0, $urandom, $urandom_range(0, 3),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)), 5'($urandom));
      tick();
    end
    drain();
    check_lat = 1'b0;

    // 64-bit instance
    wide_req(64'h8000000000000000, 7, 0, 1'b1, 5'd1);
    wide_req(64'h8000000000000000, 4, 2, 1'b0, 5'd2);
    wide_req(64'h8000000000000000, 0, 2, 1'b1, 5'd3);
    wide_req(64'h8000000000000000, 6, 1, 1'b1, 5'd4);
    for (int i = 0; i < 12; i++)
      wide_req({$urandom, $urandom}, $urandom_range(0, 7), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 5'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
